serial_adder: RTL and testbench

Bit-serial ripple adder: loads two WIDTH-bit operands and a carry-in, then adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop. It is the additive counterpart to the team's full subtractor cells and sits in the arithmetic datapath where area matters more than latency. A start/busy/done handshake frames each operation. Results are held until the next operation.

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder cell plus a carry flop.
// Ports: clk, rst (async, active-high); start, a, b, cin (operation request);
//        busy, done (handshake); sum, cout, ovf (registered result, held until
//        the next completion).
`timescale 1ns/1ps
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [WIDTH-1:0] sra;
   logic [WIDTH-1:0] srb;
   logic [WIDTH-2:0] psum;
   logic             c;
   logic [CW-1:0]    cnt;

   logic             s;
   logic             c_nx;
   logic             last;
   logic [WIDTH-1:0] ps_nx;

   assign s     = sra[0] ^ srb[0] ^ c;
   assign c_nx  = (sra[0] & srb[0]) | (c & (sra[0] ^ srb[0]));
   assign last  = (cnt == CW'(WIDTH - 1));
   // New bit enters at the top; after the final bit this is the full sum.
   assign ps_nx = {s, psum};

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sra  <= '0;
         srb  <= '0;
         psum <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sra <= a;
                  srb <= b;
                  c   <= cin;
                  cnt <= '0;
               end
            end
            RUN: begin
               sra  <= {1'b0, sra[WIDTH-1:1]};
               srb  <= {1'b0, srb[WIDTH-1:1]};
               c    <= c_nx;
               psum <= ps_nx[WIDTH-1:1];
               cnt  <= cnt + CW'(1);
               if (last) begin
                  sum  <= ps_nx;
                  cout <= c_nx;
                  // c here is the carry into the MSB
                  ovf  <= c ^ c_nx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table vectors, hand sequences and a random sweep for
// serial_adder, with a queue scoreboard fed at each accepting edge.
`timescale 1ns/1ps
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   exp_t q[$];
   vec_t tbl[9];

   int nvec    = 0;
   int nerr    = 0;
   int cyc     = 0;
   int nacc    = 0;
   int ndone   = 0;
   int acc_cyc = 0;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input int t);
      exp_t     e;
      logic [W:0] r;
      r      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.sum  = r[W-1:0];
      e.cout = r[W];
      e.ovf  = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      e.cyc  = t;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Acceptance: start high while idle at a rising edge.
   always @(posedge clk) begin
      cyc++;
      if (rst === 1'b0 && start === 1'b1 && busy === 1'b0) begin
         q.push_back(model(a, b, cin, cyc));
         nacc++;
         acc_cyc = cyc;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0) begin
         if (q.size() != 0) chk("busy_held", 32'(busy), 32'd1);
         if (done === 1'b1) begin
            ndone++;
            if (q.size() == 0) begin
               chk("spurious_done", 32'(done), 32'd0);
            end else begin
               e = q.pop_front();
               chk("sb_sum", 32'(sum), 32'(e.sum));
               chk("sb_cout", 32'(cout), 32'(e.cout));
               chk("sb_ovf", 32'(ovf), 32'(e.ovf));
               chk("latency", 32'(cyc - e.cyc), 32'(W));
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic run_op(input vec_t v);
      wait_idle();
      a     = v.a;
      b     = v.b;
      cin   = v.cin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'b0;
      wait_done();
      chk("tbl_sum", 32'(sum), 32'(v.sum));
      chk("tbl_cout", 32'(cout), 32'(v.cout));
      chk("tbl_ovf", 32'(ovf), 32'(v.ovf));
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      int   t0;
      int   n0;
      int   n;
      int   d0;
      int   a0;
      int   target;
      vec_t v;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;

      tbl[0] = '{8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
      tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[8] = '{8'hC0, 8'hA0, 1'b0, 8'h60, 1'b1, 1'b1};

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;

      foreach (tbl[i]) run_op(tbl[i]);

      // start held high; operands change while busy
      wait_idle();
      a     = 8'h10;
      b     = 8'h20;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      t0 = acc_cyc;
      a  = 8'h01;
      b  = 8'h01;
      wait_done();
      chk("hold_first", 32'(sum), 32'h30);
      n0 = nacc;
      n  = 0;
      while (nacc == n0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("reaccept_gap", 32'(acc_cyc - t0), 32'(W + 2));
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         chk("sum_hold", 32'(sum), 32'h30);
         @(negedge clk);
         n++;
      end
      chk("hold_second", 32'(sum), 32'h02);
      @(negedge clk);

      // reset during the 4th RUN cycle
      wait_idle();
      a     = 8'hAA;
      b     = 8'h55;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      q.delete();
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("abort_idle", 32'(busy), 32'd0);
      v = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
      run_op(v);

      // random sweep with frequent back-to-back starts
      d0     = ndone;
      a0     = nacc;
      target = nacc + 1000;
      n      = 0;
      while (nacc < target && n < 30000) begin
         a     = W'($urandom);
         b     = W'($urandom);
         cin   = 1'($urandom_range(0, 1));
         start = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("rand_accepts", 32'(nacc), 32'(target));
      n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rand_drain", 32'(q.size()), 32'd0);
      chk("done_count", 32'(ndone - d0), 32'(nacc - a0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
